fk_history_seq: RTL

FK_HISTORY_SEQ -- requirements
Module: fk_history_seq

---
 rtl/fk_pkg.sv | 23 ++
 rtl/fk_shift3.sv | 33 +++
 rtl/fk_history_seq.sv | 133 +++++++++++++
 3 files changed

// File: rtl/fk_pkg.sv
// fk_pkg -- constants shared by the f(k) history sequencer and the
// downstream f(k) tap mux.
//
// Contents:
//   SEL_FK / SEL_FK1 / SEL_FK2 / SEL_ZERO : tap select codes; SEL_ZERO makes
//                                           the downstream mux output zero.
//   fk_state_t                            : sequencer FSM state encoding.
package fk_pkg;

  localparam logic [1:0] SEL_FK   = 2'b00;
  localparam logic [1:0] SEL_FK1  = 2'b01;
  localparam logic [1:0] SEL_FK2  = 2'b10;
  localparam logic [1:0] SEL_ZERO = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_TAP0 = 3'd1,
    ST_TAP1 = 3'd2,
    ST_TAP2 = 3'd3,
    ST_DONE = 3'd4
  } fk_state_t;

endpackage

// File: rtl/fk_shift3.sv
// fk_shift3 -- three-deep N-bit delay line holding f(k), f(k-1), f(k-2).
//
// Ports:
//   clk      : clock, rising edge
//   reset_n  : synchronous active-low reset, clears all three registers
//   load     : shift d in; q0<=d, q1<=q0, q2<=q1 on the same edge
//   d        : new sample
//   q0/q1/q2 : f(k), f(k-1), f(k-2); held whenever load is low
module fk_shift3 #(
  parameter int N = 25
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load,
  input  logic [N-1:0] d,
  output logic [N-1:0] q0,
  output logic [N-1:0] q1,
  output logic [N-1:0] q2
);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      q0 <= '0;
      q1 <= '0;
      q2 <= '0;
    end else if (load) begin
      q0 <= d;
      q1 <= q0;
      q2 <= q1;
    end
  end

endmodule

// File: rtl/fk_history_seq.sv
// fk_history_seq -- accepts one sample per frame, shifts it into a
// three-deep history and then walks the downstream tap mux over
// f(k), f(k-1), f(k-2), closing the frame with a one-cycle frame_done.
//
// Ports:
//   clk, reset_n    : clock and synchronous active-low reset
//   sample_valid    : upstream offers sample_in
//   sample_in [N]   : new sample f(k)
//   sample_ready    : high only in IDLE
//   fk, fk_1, fk_2  : registered history f(k), f(k-1), f(k-2)
//   sel [2]         : tap select (fk_pkg SEL_* codes)
//   sel_valid       : sel addresses a real tap this cycle
//   frame_done      : one-cycle pulse after the last tap
//   dbg_state [3]   : current FSM state (fk_state_t encoding)
//   hist_full       : only with FK_FILL_STATUS_EN; three or more samples
//                     accepted since reset
//
// Build option FK_FILL_STATUS_EN: adds hist_full and a saturating fill
// counter; sel_valid is then also gated by hist_full.
//
// Handshake: a sample transfers on a rising edge where sample_valid and
// sample_ready are both high; upstream holds sample_in stable until then,
// and sample_valid is ignored while sample_ready is low.
module fk_history_seq
  import fk_pkg::*;
#(
  parameter int N = 25
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         sample_valid,
  input  logic [N-1:0] sample_in,
  output logic         sample_ready,
  output logic [N-1:0] fk,
  output logic [N-1:0] fk_1,
  output logic [N-1:0] fk_2,
  output logic [1:0]   sel,
  output logic         sel_valid,
  output logic         frame_done,
`ifdef FK_FILL_STATUS_EN
  output logic         hist_full,
`endif
  output logic [2:0]   dbg_state
);

  fk_state_t state;
  logic      tap_valid;
  logic      accept;

  // sample_ready is registered and high exactly in IDLE, so this is the
  // acceptance edge.
  assign accept    = sample_valid & sample_ready;
  assign dbg_state = state;

  fk_shift3 #(.N(N)) u_shift3 (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (accept),
    .d       (sample_in),
    .q0      (fk),
    .q1      (fk_1),
    .q2      (fk_2)
  );

  // All outputs are loaded with the values of the state being entered, so
  // they are aligned with state and glitch-free.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state        <= ST_IDLE;
      sel          <= SEL_ZERO;
      tap_valid    <= 1'b0;
      frame_done   <= 1'b0;
      sample_ready <= 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          if (sample_valid) begin
            state        <= ST_TAP0;
            sel          <= SEL_FK;
            tap_valid    <= 1'b1;
            sample_ready <= 1'b0;
          end
        end
        ST_TAP0: begin
          state <= ST_TAP1;
          sel   <= SEL_FK1;
        end
        ST_TAP1: begin
          state <= ST_TAP2;
          sel   <= SEL_FK2;
        end
        ST_TAP2: begin
          state      <= ST_DONE;
          sel        <= SEL_ZERO;
          tap_valid  <= 1'b0;
          frame_done <= 1'b1;
        end
        ST_DONE: begin
          state        <= ST_IDLE;
          frame_done   <= 1'b0;
          sample_ready <= 1'b1;
        end
        default: begin
          state        <= ST_IDLE;
          sel          <= SEL_ZERO;
          tap_valid    <= 1'b0;
          frame_done   <= 1'b0;
          sample_ready <= 1'b1;
        end
      endcase
    end
  end

`ifdef FK_FILL_STATUS_EN
  logic [1:0] fill_cnt;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      fill_cnt <= 2'd0;
    end else if (accept && (fill_cnt != 2'd3)) begin
      fill_cnt <= fill_cnt + 2'd1;
    end
  end

  // The counter updates on the acceptance edge, so the frame carrying the
  // third sample already sees hist_full in TAP0.
  assign hist_full = (fill_cnt == 2'd3);
  assign sel_valid = tap_valid & hist_full;
`else
  assign sel_valid = tap_valid;
`endif

endmodule
